// File: rtl/stream_frame_writer_pkg.sv
// stream_writer_pkg: shared state type, default frame geometry and pixel packing
// for the stream_frame_writer block.
package stream_writer_pkg;

  localparam int H_RES_DEF    = 320;
  localparam int V_RES_DEF    = 240;
  localparam int FRAME_PIXELS = H_RES_DEF * V_RES_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Keeps the top 4 bits of each 10-bit channel; plain truncation, no rounding.
  function automatic logic [11:0] pack_rgb30_to_12(input logic [29:0] rgb);
    return {rgb[29:26], rgb[19:16], rgb[9:6]};
  endfunction

endpackage

// File: rtl/stream_frame_writer_if.sv
// stream_frame_writer_if: 30-bit RGB pixel stream with sop/eop framing and a
// valid/ready handshake; the writer sits on the slave side.
interface stream_frame_writer_if #(
  parameter int DATA_W = 30
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic              in_ready;

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input  in_ready
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    output in_ready
  );

endinterface

// File: rtl/stream_frame_writer_counter.sv
// frame_addr_counter: pixel index within the frame; clear and inc may be combined,
// which loads 1 (pixel 0 is being written this cycle, the next beat is pixel 1).
module frame_addr_counter #(
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              is_last
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = (clear ? '0 : count_q) + ADDR_W'(inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_last = (count_q == LAST);

endmodule

// File: rtl/stream_frame_writer.sv
// stream_frame_writer: captures sop/eop framed RGB30 pixels into a 12-bit frame buffer
// write port. Define STREAM_WRITER_ERRCNT_EN to add the saturating err_count output.
module stream_frame_writer
  import stream_writer_pkg::*;
#(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int DATA_W = 30,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  stream_frame_writer_if.slave strm,
  input  logic                 arm,
  input  logic                 continuous,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [PIX_W-1:0]     wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_long
`ifdef STREAM_WRITER_ERRCNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  localparam int FRAME_PIX = H_RES * V_RES;

  state_t            state_q, state_d;
  state_t            end_state;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_done_q, frame_done_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic              beat_acc;
  logic              cnt_clear, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] pix_in;

  // The sink never backpressures; only reset holds ready low.
  assign strm.in_ready = ~reset;
  assign beat_acc      = strm.in_valid & strm.in_ready;
  assign pix_in        = strm.in_data;
  assign end_state     = continuous ? SYNC : IDLE;

  frame_addr_counter #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FRAME_PIX)
  ) u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .count   (cnt),
    .is_last (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (beat_acc && strm.in_sop) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = pack_rgb30_to_12(pix_in);
          cnt_clear = 1'b1;
          cnt_inc   = ~strm.in_eop;
          if (strm.in_eop) begin
            err_short_d = 1'b1;
            state_d     = end_state;
          end else begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        if (beat_acc) begin
          wr_en_d   = 1'b1;
          wr_data_d = pack_rgb30_to_12(pix_in);
          if (strm.in_sop) begin
            // A fresh sop truncates the current frame and restarts at pixel 0.
            wr_addr_d   = '0;
            err_short_d = 1'b1;
            cnt_clear   = 1'b1;
            cnt_inc     = ~strm.in_eop;
            if (strm.in_eop) begin
              state_d = end_state;
            end
          end else begin
            wr_addr_d = cnt;
            if (cnt_last) begin
              cnt_clear = 1'b1;
              if (strm.in_eop) begin
                frame_done_d = 1'b1;
                state_d      = end_state;
              end else begin
                err_long_d = 1'b1;
                state_d    = DRAIN;
              end
            end else if (strm.in_eop) begin
              err_short_d = 1'b1;
              cnt_clear   = 1'b1;
              state_d     = end_state;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (beat_acc && strm.in_eop) begin
          state_d = end_state;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign busy       = (state_q != IDLE);

`ifdef STREAM_WRITER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       arm_accept;

  assign arm_accept = (state_q == IDLE) && arm;

  // Counted on the same edge that registers the error pulse, so both appear together.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (arm_accept) begin
      err_cnt_d = '0;
    end else if ((err_short_d || err_long_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_stream_frame_writer.sv
// Bench for stream_frame_writer: scoreboard of expected frame-buffer writes on a 4x2
// frame, plus one long frame through a 64x48 instance.
module tb_stream_frame_writer;

  localparam logic [29:0] K = 30'h0040_1004;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
    logic        done;
    logic        es;
    logic        el;
  } wr_t;

  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];
  logic busy_dropped;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        arm;
  logic        continuous;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_en, busy, frame_done, err_short, err_long;
`ifdef STREAM_WRITER_ERRCNT_EN
  logic [7:0]  err_count;
  logic [7:0]  b_err_count;
`endif

  logic        b_arm;
  logic [11:0] b_wr_addr;
  logic [11:0] b_wr_data;
  logic        b_wr_en, b_busy, b_frame_done, b_err_short, b_err_long;

  stream_frame_writer_if #(.DATA_W(30)) sif ();
  stream_frame_writer_if #(.DATA_W(30)) bif ();

  stream_frame_writer #(
    .H_RES(4), .V_RES(2), .DATA_W(30), .ADDR_W(3), .PIX_W(12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .strm       (sif),
    .arm        (arm),
    .continuous (continuous),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .busy       (busy),
    .frame_done (frame_done),
    .err_short  (err_short),
    .err_long   (err_long)
`ifdef STREAM_WRITER_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  stream_frame_writer #(
    .H_RES(64), .V_RES(48), .DATA_W(30), .ADDR_W(12), .PIX_W(12)
  ) dut_big (
    .clk        (clk),
    .reset      (reset),
    .strm       (bif),
    .arm        (b_arm),
    .continuous (1'b0),
    .wr_addr    (b_wr_addr),
    .wr_data    (b_wr_data),
    .wr_en      (b_wr_en),
    .busy       (b_busy),
    .frame_done (b_frame_done),
    .err_short  (b_err_short),
    .err_long   (b_err_long)
`ifdef STREAM_WRITER_ERRCNT_EN
    ,
    .err_count  (b_err_count)
`endif
  );

  function automatic logic [11:0] px(input logic [29:0] d);
    return {d[29:26], d[19:16], d[9:6]};
  endfunction

  function automatic wr_t mk(input int a, input logic [11:0] d, input logic f,
                             input logic s, input logic l);
    wr_t w;
    w.addr = 17'(a);
    w.data = d;
    w.done = f;
    w.es   = s;
    w.el   = l;
    return w;
  endfunction

  // One stream beat: drive, clock, record any write or status pulse.
  task automatic beat(input logic v, input logic sop, input logic eop, input logic [29:0] d);
    sif.in_valid = v;
    sif.in_sop   = sop;
    sif.in_eop   = eop;
    sif.in_data  = d;
    @(posedge clk);
    #1;
    if (!busy) busy_dropped = 1'b1;
    if (wr_en || frame_done || err_short || err_long) begin
      obs_q.push_back(mk(int'(wr_addr), wr_data, frame_done, err_short, err_long));
      $display("%0t WR addr=%0d data=%03h done=%b es=%b el=%b",
               $time, wr_addr, wr_data, frame_done, err_short, err_long);
    end
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    beat(1'b0, 1'b0, 1'b0, 30'd0);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b0 || frame_done !== 1'b0 || err_short !== 1'b0 || err_long !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got wr_en=%b done=%b es=%b el=%b required all 0",
               wr_en, frame_done, err_short, err_long);
    end
    checks++;
    if (wr_addr !== 3'd0 || wr_data !== 12'd0) begin
      failures++;
      $display("FAIL reset_bus got addr=%0d data=%03h required 0/000", wr_addr, wr_data);
    end
    checks++;
    if (busy !== 1'b0 || sif.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_ready got busy=%b ready=%b required 0/0", busy, sif.in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (sif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b required=1", sif.in_ready);
    end
  endtask

  task automatic test_good_frame();
    wr_t e, o;
    arm_pulse();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL good_busy_after_arm got=%b required=1", busy);
    end
    beat(1'b1, 1'b0, 1'b0, 30'h3FFF_FFFF);  // non-sop beat in SYNC must be dropped
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(i, px(30'(i) * K), i == 7, 1'b0, 1'b0));
      beat(1'b1, i == 0, i == 7, 30'(i) * K);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL good_idle_after got busy=%b required=0", busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL good_nwrites got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL good_write got=%h required=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_short_frame();
    wr_t e, o;
    logic [29:0] d;
    arm_pulse();
    for (int i = 0; i < 5; i++) begin
      d = 30'($urandom);
      exp_q.push_back(mk(i, px(d), 1'b0, i == 4, 1'b0));
      beat(1'b1, i == 0, i == 4, d);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL short_idle_after got busy=%b required=0", busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL short_nwrites got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL short_write got=%h required=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_long_frame();
    wr_t e, o;
    logic [29:0] d;
    arm_pulse();
    for (int i = 0; i < 11; i++) begin
      d = 30'($urandom);
      if (i < 8) exp_q.push_back(mk(i, px(d), 1'b0, 1'b0, i == 7));
      beat(1'b1, i == 0, i == 10, d);
      if (i == 9) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL long_drain_busy got=%b required=1", busy);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL long_idle_after got busy=%b required=0", busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL long_nwrites got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL long_write got=%h required=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_resync();
    wr_t e, o;
    logic [29:0] d;
    int a;
    arm_pulse();
    for (int i = 0; i < 11; i++) begin
      d = 30'($urandom);
      a = (i < 3) ? i : i - 3;
      exp_q.push_back(mk(a, px(d), i == 10, i == 3, 1'b0));
      beat(1'b1, (i == 0) || (i == 3), i == 10, d);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL resync_nwrites got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL resync_write got=%h required=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_continuous();
    wr_t e, o;
    logic [29:0] d;
    continuous = 1'b1;
    arm_pulse();
    busy_dropped = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        d = 30'($urandom);
        exp_q.push_back(mk(i, px(d), i == 7, 1'b0, 1'b0));
        beat(1'b1, i == 0, i == 7, d);
        beat(1'b0, 1'b0, 1'b0, 30'($urandom));
      end
    end
    checks++;
    if (busy_dropped !== 1'b0) begin
      failures++;
      $display("FAIL cont_busy_kept got dropped=%b required=0", busy_dropped);
    end
    // sop+eop on one beat in SYNC with continuous now low: truncated frame, back to IDLE.
    continuous = 1'b0;
    exp_q.push_back(mk(0, 12'hA5C, 1'b0, 1'b1, 1'b0));
    beat(1'b1, 1'b1, 1'b1, 30'h2805_0300);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_idle_after got busy=%b required=0", busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL cont_nwrites got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL cont_write got=%h required=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    wr_t e, o;
    logic [29:0] d;
    arm_pulse();
    for (int i = 0; i < 2; i++) begin
      d = 30'($urandom) | 30'h2000_0000;
      exp_q.push_back(mk(i, px(d), 1'b0, 1'b0, 1'b0));
      beat(1'b1, i == 0, 1'b0, d);
    end
    reset = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 30'($urandom));
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || sif.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl got wr_en=%b busy=%b ready=%b required 0/0/0",
               wr_en, busy, sif.in_ready);
    end
    checks++;
    if (wr_addr !== 3'd0 || wr_data !== 12'd0) begin
      failures++;
      $display("FAIL midreset_bus got addr=%0d data=%03h required 0/000", wr_addr, wr_data);
    end
    beat(1'b0, 1'b0, 1'b0, 30'd0);
    reset = 1'b0;
    arm_pulse();
    for (int i = 0; i < 8; i++) begin
      d = 30'($urandom);
      exp_q.push_back(mk(i, px(d), i == 7, 1'b0, 1'b0));
      beat(1'b1, i == 0, i == 7, d);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midreset_nwrites got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midreset_write got=%h required=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

`ifdef STREAM_WRITER_ERRCNT_EN
  task automatic test_errcnt();
    logic [29:0] d;
    continuous = 1'b1;
    arm_pulse();
    checks++;
    if (err_count !== 8'd0) begin
      failures++;
      $display("FAIL errcnt_arm_clear got=%0d required=0", err_count);
    end
    for (int i = 0; i < 300; i++) begin
      d = 30'($urandom);
      beat(1'b1, 1'b1, 1'b1, d);
      if (i == 2) begin
        checks++;
        if (err_count !== 8'd3) begin
          failures++;
          $display("FAIL errcnt_three got=%0d required=3", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL errcnt_saturate got=%0d required=255", err_count);
    end
    continuous = 1'b0;
    beat(1'b1, 1'b1, 1'b1, 30'($urandom));
    checks++;
    if (err_count !== 8'd255 || busy !== 1'b0) begin
      failures++;
      $display("FAIL errcnt_hold got cnt=%0d busy=%b required 255/0", err_count, busy);
    end
    arm_pulse();
    beat(1'b1, 1'b1, 1'b1, 30'($urandom));
    checks++;
    if (err_count !== 8'd1) begin
      failures++;
      $display("FAIL errcnt_rearm got=%0d required=1", err_count);
    end
    obs_q.delete();
  endtask
`endif

  task automatic test_big_frame();
    int          n_wr    = 0;
    int          n_done  = 0;
    int          done_at = -1;
    logic        bad_err = 1'b0;
    logic [11:0] last_a  = '0;
    logic [11:0] last_d  = '0;
    logic [29:0] d       = '0;
    b_arm = 1'b1;
    @(posedge clk);
    #1;
    b_arm = 1'b0;
    for (int i = 0; i < 3072; i++) begin
      d = 30'($urandom);
      bif.in_valid = 1'b1;
      bif.in_sop   = (i == 0);
      bif.in_eop   = (i == 3071);
      bif.in_data  = d;
      @(posedge clk);
      #1;
      if (b_wr_en) begin
        n_wr++;
        last_a = b_wr_addr;
        last_d = b_wr_data;
      end
      if (b_frame_done) begin
        n_done++;
        done_at = i;
      end
      if (b_err_short || b_err_long) bad_err = 1'b1;
    end
    bif.in_valid = 1'b0;
    bif.in_sop   = 1'b0;
    bif.in_eop   = 1'b0;
    $display("%0t BIG frame writes=%0d last_addr=%0d done_at=%0d", $time, n_wr, last_a, done_at);
    checks++;
    if (n_wr != 3072 || last_a !== 12'd3071) begin
      failures++;
      $display("FAIL big_last_addr got n=%0d addr=%0d required 3072/3071", n_wr, last_a);
    end
    checks++;
    if (last_d !== px(d)) begin
      failures++;
      $display("FAIL big_last_data got=%03h required=%03h", last_d, px(d));
    end
    checks++;
    if (n_done != 1 || done_at != 3071 || bad_err !== 1'b0) begin
      failures++;
      $display("FAIL big_done got pulses=%0d at=%0d err=%b required 1/3071/0",
               n_done, done_at, bad_err);
    end
    checks++;
    if (b_busy !== 1'b0) begin
      failures++;
      $display("FAIL big_idle_after got busy=%b required=0", b_busy);
    end
  endtask

  initial begin
    reset        = 1'b1;
    arm          = 1'b0;
    continuous   = 1'b0;
    b_arm        = 1'b0;
    busy_dropped = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_sop   = 1'b0;
    sif.in_eop   = 1'b0;
    sif.in_data  = '0;
    bif.in_valid = 1'b0;
    bif.in_sop   = 1'b0;
    bif.in_eop   = 1'b0;
    bif.in_data  = '0;

    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_resync();
    test_continuous();
    test_reset_mid();
`ifdef STREAM_WRITER_ERRCNT_EN
    test_errcnt();
`endif
    test_big_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
